// File: rtl/plic_regfile_if.sv
// Bus request/response bundle between a bus master and the PLIC register file.
// One request per cycle; the response follows one cycle after acceptance.
interface plic_regfile_if #(
   parameter int ADDR_WIDTH = 24
);
   logic                  bus_req_valid;
   logic                  bus_req_ready;
   logic                  bus_req_we;
   logic [ADDR_WIDTH-1:0] bus_req_addr;
   logic [31:0]           bus_req_wdata;
   logic                  bus_rsp_valid;
   logic [31:0]           bus_rsp_rdata;
   logic                  bus_rsp_err;

   modport master (
      output bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata,
      input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
   );

   modport slave (
      input  bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata,
      output bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
   );
endinterface

// File: rtl/plic_regfile.sv
// PLIC target-0 register file: prio/ip/ie/threshold plus the nested claim/complete stack.
// Optional macro PLIC_ERR_RSP_EN enables bus_rsp_err reporting; otherwise it is tied to 0.
module plic_regfile #(
   parameter int EXT_IRQ_NUM = 31,
   parameter int PRIO_WIDTH  = 3,
   parameter int NEST_DEPTH  = 4,
   parameter int ADDR_WIDTH  = 24
) (
   input  logic                                  clk,
   input  logic                                  rst,
   plic_regfile_if.slave                         bus,
   input  logic [EXT_IRQ_NUM:0]                  plic_reg_gate,
   input  logic [7:0]                            final_id,
   output logic [EXT_IRQ_NUM:0]                  ip_r,
   output logic [EXT_IRQ_NUM:0]                  ie_r,
   output logic [PRIO_WIDTH*(EXT_IRQ_NUM+1)-1:0] prio_r_1d,
   output logic [PRIO_WIDTH-1:0]                 threshold_r,
   output logic [7:0]                            claim_id,
   output logic [7:0]                            cmplt_id
);
   localparam int unsigned N   = EXT_IRQ_NUM;
   localparam int unsigned PW  = PRIO_WIDTH;
   localparam int unsigned SPW = $clog2(NEST_DEPTH + 1);

   localparam logic [ADDR_WIDTH-1:0] A_IP  = ADDR_WIDTH'(32'h0000_1000);
   localparam logic [ADDR_WIDTH-1:0] A_IE  = ADDR_WIDTH'(32'h0000_2000);
   localparam logic [ADDR_WIDTH-1:0] A_THR = ADDR_WIDTH'(32'h0020_0000);
   localparam logic [ADDR_WIDTH-1:0] A_CC  = ADDR_WIDTH'(32'h0020_0004);
   localparam logic [N:0]            IRQ_MASK = {{N{1'b1}}, 1'b0};

   logic             r_ready;
   logic [N:0]       r_ip;
   logic [N:0]       r_ie;
   logic [PW-1:0]    r_prio [0:N];
   logic [PW-1:0]    r_thr;
   logic [7:0]       r_stack [0:NEST_DEPTH-1];
   logic [SPW-1:0]   r_sp;
   logic             r_rsp_valid;
   logic [31:0]      r_rsp_rdata;
   logic [7:0]       r_cmplt;

   logic             w_acc;
   logic             w_rd;
   logic             w_wr;
   logic             w_is_prio;
   logic [PW-1:0]    w_prio_rd;
   logic [PW-1:0]    w_p_final;
   logic [PW-1:0]    w_p_top;
   logic             w_f_pend;
   logic [N:0]       w_f_onehot;
   logic [N:0]       w_ip_clr;
   logic [7:0]       w_top;
   logic             w_full;
   logic             w_claim;
   logic             w_grant;
   logic             w_cmp;
   logic [7:0]       w_c;
   logic             w_c_legal;
   logic             w_pop;
   logic [31:0]      w_rdata;

   assign w_acc = bus.bus_req_valid & r_ready;
   assign w_rd  = w_acc & ~bus.bus_req_we;
   assign w_wr  = w_acc & bus.bus_req_we;

   always_comb begin
      w_top = '0;
      for (int unsigned i = 0; i < NEST_DEPTH; i++) begin
         if (r_sp == SPW'(i + 1)) w_top = r_stack[i];
      end
   end

   // Source-indexed lookups as explicit muxes so out-of-range IDs simply miss
   always_comb begin
      w_is_prio  = 1'b0;
      w_prio_rd  = '0;
      w_p_final  = '0;
      w_p_top    = '0;
      w_f_pend   = 1'b0;
      w_f_onehot = '0;
      for (int unsigned k = 0; k <= N; k++) begin
         if (bus.bus_req_addr == ADDR_WIDTH'(4 * k)) begin
            w_is_prio = 1'b1;
            w_prio_rd = r_prio[k];
         end
         if (final_id == 8'(k)) begin
            w_p_final     = r_prio[k];
            w_f_pend      = r_ip[k] & r_ie[k];
            w_f_onehot[k] = 1'b1;
         end
         if (w_top == 8'(k)) w_p_top = r_prio[k];
      end
   end

   assign w_full    = (r_sp == SPW'(NEST_DEPTH));
   assign w_claim   = w_rd && (bus.bus_req_addr == A_CC);
   assign w_grant   = w_claim && !w_full && w_f_pend &&
                      (w_p_final > r_thr) && (w_p_final > w_p_top);
   assign w_ip_clr  = w_grant ? w_f_onehot : '0;
   assign w_cmp     = w_wr && (bus.bus_req_addr == A_CC);
   assign w_c       = bus.bus_req_wdata[7:0];
   assign w_c_legal = (w_c != 8'd0) && (w_c <= 8'(N));
   assign w_pop     = w_cmp && w_c_legal && (r_sp != '0) && (w_c == w_top);

   always_comb begin
      w_rdata = '0;
      if (!bus.bus_req_we) begin
         if (w_is_prio)                        w_rdata = 32'(w_prio_rd);
         else if (bus.bus_req_addr == A_IP)    w_rdata = 32'(r_ip);
         else if (bus.bus_req_addr == A_IE)    w_rdata = 32'(r_ie);
         else if (bus.bus_req_addr == A_THR)   w_rdata = 32'(r_thr);
         else if (bus.bus_req_addr == A_CC)    w_rdata = w_grant ? 32'(final_id) : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ready     <= 1'b0;
         r_ip        <= '0;
         r_ie        <= '0;
         r_thr       <= '0;
         r_sp        <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_cmplt     <= '0;
         for (int unsigned k = 0; k <= N; k++) r_prio[k] <= '0;
         for (int unsigned i = 0; i < NEST_DEPTH; i++) r_stack[i] <= '0;
      end else begin
         r_ready     <= 1'b1;
         r_rsp_valid <= w_acc;
         r_rsp_rdata <= w_acc ? w_rdata : '0;
         r_cmplt     <= (w_cmp && w_c_legal) ? w_c : '0;
         // Claim clear takes priority over a same-cycle gateway set
         r_ip        <= (r_ip | plic_reg_gate) & ~w_ip_clr & IRQ_MASK;
         if (w_wr && (bus.bus_req_addr == A_IE))  r_ie  <= bus.bus_req_wdata[N:0] & IRQ_MASK;
         if (w_wr && (bus.bus_req_addr == A_THR)) r_thr <= bus.bus_req_wdata[PW-1:0];
         for (int unsigned k = 1; k <= N; k++) begin
            if (w_wr && (bus.bus_req_addr == ADDR_WIDTH'(4 * k)))
               r_prio[k] <= bus.bus_req_wdata[PW-1:0];
         end
         if (w_grant) begin
            for (int unsigned i = 0; i < NEST_DEPTH; i++) begin
               if (r_sp == SPW'(i)) r_stack[i] <= final_id;
            end
            r_sp <= r_sp + SPW'(1);
         end else if (w_pop) begin
            r_sp <= r_sp - SPW'(1);
         end
      end
   end

`ifdef PLIC_ERR_RSP_EN
   logic w_err;
   logic r_rsp_err;

   always_comb begin
      w_err = 1'b1;
      if (w_is_prio || (bus.bus_req_addr == A_IE) || (bus.bus_req_addr == A_THR))
         w_err = 1'b0;
      else if (bus.bus_req_addr == A_IP)
         w_err = bus.bus_req_we;
      else if (bus.bus_req_addr == A_CC)
         w_err = bus.bus_req_we ? !w_pop : w_full;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_rsp_err <= 1'b0;
      else     r_rsp_err <= w_acc & w_err;
   end

   assign bus.bus_rsp_err = r_rsp_err;
`else
   assign bus.bus_rsp_err = 1'b0;
`endif

   always_comb begin
      prio_r_1d = '0;
      for (int unsigned k = 0; k <= N; k++) prio_r_1d[k*PW +: PW] = r_prio[k];
   end

   assign bus.bus_req_ready = r_ready;
   assign bus.bus_rsp_valid = r_rsp_valid;
   assign bus.bus_rsp_rdata = r_rsp_rdata;
   assign ip_r              = r_ip;
   assign ie_r              = r_ie;
   assign threshold_r       = r_thr;
   assign claim_id          = w_top;
   assign cmplt_id          = r_cmplt;
endmodule

// File: tb/tb_plic_regfile.sv
// Self-checking bench for plic_regfile: bus responses go through an expected/actual
// scoreboard queue pair, side outputs are compared inline in each scenario task.
module tb_plic_regfile;
   localparam int N     = 31;
   localparam int PW    = 3;
   localparam int DEPTH = 4;
   localparam int AW    = 24;
`ifdef PLIC_ERR_RSP_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic [N:0]         gate = '0;
   logic [7:0]         final_id = '0;
   logic [N:0]         ip_r;
   logic [N:0]         ie_r;
   logic [PW*(N+1)-1:0] prio_r_1d;
   logic [PW-1:0]      threshold_r;
   logic [7:0]         claim_id;
   logic [7:0]         cmplt_id;

   plic_regfile_if #(.ADDR_WIDTH(AW)) bus();

   plic_regfile #(
      .EXT_IRQ_NUM(N), .PRIO_WIDTH(PW), .NEST_DEPTH(DEPTH), .ADDR_WIDTH(AW)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .plic_reg_gate(gate), .final_id(final_id),
      .ip_r(ip_r), .ie_r(ie_r), .prio_r_1d(prio_r_1d), .threshold_r(threshold_r),
      .claim_id(claim_id), .cmplt_id(cmplt_id)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   logic [32:0] exp_q[$];
   logic [32:0] act_q[$];

   always @(negedge clk)
      if (bus.bus_rsp_valid === 1'b1) act_q.push_back({bus.bus_rsp_err, bus.bus_rsp_rdata});

   task automatic bus_op(input logic we, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [31:0] er, input logic eerr);
      bus.bus_req_valid = 1'b1;
      bus.bus_req_we    = we;
      bus.bus_req_addr  = a;
      bus.bus_req_wdata = d;
      exp_q.push_back({eerr & ERR_EN, er});
      @(negedge clk);
      bus.bus_req_valid = 1'b0;
   endtask

   task automatic test_reset;
      logic [32:0] e, a;
      bus.bus_req_valid = 1'b0; bus.bus_req_we = 1'b0;
      bus.bus_req_addr = '0; bus.bus_req_wdata = '0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      n_chk++; if (bus.bus_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", bus.bus_req_ready); end
      n_chk++; if (bus.bus_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", bus.bus_rsp_valid); end
      n_chk++; if ({ip_r, ie_r, threshold_r} !== '0) begin n_fail++; $display("FAIL rst_ip_ie_thr: got %h want 0", {ip_r, ie_r, threshold_r}); end
      n_chk++; if (prio_r_1d !== '0) begin n_fail++; $display("FAIL rst_prio: got %h want 0", prio_r_1d); end
      n_chk++; if ({claim_id, cmplt_id} !== 16'h0) begin n_fail++; $display("FAIL rst_ids: got %h want 0", {claim_id, cmplt_id}); end
      rst = 1'b0;
      @(negedge clk);
      n_chk++; if (bus.bus_req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_rst: got %b want 1", bus.bus_req_ready); end
      for (int k = 0; k <= N; k++) bus_op(1'b0, AW'(4 * k), '0, '0, 1'b0);
      bus_op(1'b0, 24'h001000, '0, '0, 1'b0);
      bus_op(1'b0, 24'h002000, '0, '0, 1'b0);
      bus_op(1'b0, 24'h200000, '0, '0, 1'b0);
      bus_op(1'b0, 24'h200004, '0, '0, 1'b0);
      repeat (2) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_chk++;
         if (act_q.size() == 0) begin n_fail++; $display("FAIL reset_rsp: got none want err=%b rdata=%h", e[32], e[31:0]); end
         else begin a = act_q.pop_front(); if (a !== e) begin n_fail++; $display("FAIL reset_rsp: got err=%b rdata=%h want err=%b rdata=%h", a[32], a[31:0], e[32], e[31:0]); end end
      end
      n_chk++; if (act_q.size() != 0) begin n_fail++; $display("FAIL reset_extra_rsp: got %0d want 0", act_q.size()); act_q.delete(); end
   endtask

   task automatic test_claim;
      logic [32:0] e, a;
      bus_op(1'b1, 24'h000014, 32'hFB, '0, 1'b0);
      bus_op(1'b1, 24'h000000, 32'h07, '0, 1'b0);
      bus_op(1'b1, 24'h002000, 32'h21, '0, 1'b0);
      bus_op(1'b1, 24'h200000, 32'h09, '0, 1'b0);
      n_chk++; if (prio_r_1d[5*PW +: PW] !== 3'd3) begin n_fail++; $display("FAIL prio5_out: got %0d want 3", prio_r_1d[5*PW +: PW]); end
      n_chk++; if (prio_r_1d[0 +: PW] !== 3'd0) begin n_fail++; $display("FAIL prio0_out: got %0d want 0", prio_r_1d[0 +: PW]); end
      n_chk++; if (ie_r !== 32'h20) begin n_fail++; $display("FAIL ie_out: got %h want 20", ie_r); end
      n_chk++; if (threshold_r !== 3'd1) begin n_fail++; $display("FAIL thr_out: got %0d want 1", threshold_r); end
      bus_op(1'b0, 24'h000014, '0, 32'd3, 1'b0);
      bus_op(1'b0, 24'h000000, '0, 32'd0, 1'b0);
      bus_op(1'b0, 24'h002000, '0, 32'h20, 1'b0);
      bus_op(1'b0, 24'h200000, '0, 32'd1, 1'b0);
      gate[5] = 1'b1; @(negedge clk); gate[5] = 1'b0;
      n_chk++; if (ip_r !== 32'h20) begin n_fail++; $display("FAIL ip5_set: got %h want 20", ip_r); end
      final_id = 8'd5;
      bus_op(1'b0, 24'h200004, '0, 32'd5, 1'b0);
      n_chk++; if (ip_r !== 32'h0) begin n_fail++; $display("FAIL ip5_clr: got %h want 0", ip_r); end
      n_chk++; if (claim_id !== 8'd5) begin n_fail++; $display("FAIL claim5_id: got %0d want 5", claim_id); end
      bus_op(1'b0, 24'h001000, '0, 32'h0, 1'b0);
      repeat (2) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_chk++;
         if (act_q.size() == 0) begin n_fail++; $display("FAIL claim_rsp: got none want err=%b rdata=%h", e[32], e[31:0]); end
         else begin a = act_q.pop_front(); if (a !== e) begin n_fail++; $display("FAIL claim_rsp: got err=%b rdata=%h want err=%b rdata=%h", a[32], a[31:0], e[32], e[31:0]); end end
      end
      n_chk++; if (act_q.size() != 0) begin n_fail++; $display("FAIL claim_extra_rsp: got %0d want 0", act_q.size()); act_q.delete(); end
   endtask

   task automatic test_nesting;
      logic [32:0] e, a;
      bus_op(1'b1, 24'h00001C, 32'd6, '0, 1'b0);
      bus_op(1'b1, 24'h002000, 32'hA0, '0, 1'b0);
      gate[7] = 1'b1; @(negedge clk); gate[7] = 1'b0;
      final_id = 8'd7;
      bus_op(1'b0, 24'h200004, '0, 32'd7, 1'b0);
      n_chk++; if (claim_id !== 8'd7) begin n_fail++; $display("FAIL nest_claim7: got %0d want 7", claim_id); end
      bus_op(1'b1, 24'h200004, 32'd7, '0, 1'b0);
      n_chk++; if (cmplt_id !== 8'd7) begin n_fail++; $display("FAIL cmplt7_pulse: got %0d want 7", cmplt_id); end
      n_chk++; if (claim_id !== 8'd5) begin n_fail++; $display("FAIL nest_pop7: got %0d want 5", claim_id); end
      @(negedge clk);
      n_chk++; if (cmplt_id !== 8'd0) begin n_fail++; $display("FAIL cmplt7_end: got %0d want 0", cmplt_id); end
      bus_op(1'b1, 24'h200004, 32'd5, '0, 1'b0);
      n_chk++; if (cmplt_id !== 8'd5) begin n_fail++; $display("FAIL cmplt5_pulse: got %0d want 5", cmplt_id); end
      n_chk++; if (claim_id !== 8'd0) begin n_fail++; $display("FAIL nest_pop5: got %0d want 0", claim_id); end
      repeat (2) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_chk++;
         if (act_q.size() == 0) begin n_fail++; $display("FAIL nest_rsp: got none want err=%b rdata=%h", e[32], e[31:0]); end
         else begin a = act_q.pop_front(); if (a !== e) begin n_fail++; $display("FAIL nest_rsp: got err=%b rdata=%h want err=%b rdata=%h", a[32], a[31:0], e[32], e[31:0]); end end
      end
      n_chk++; if (act_q.size() != 0) begin n_fail++; $display("FAIL nest_extra_rsp: got %0d want 0", act_q.size()); act_q.delete(); end
   endtask

   task automatic test_threshold_clear;
      logic [32:0] e, a;
      bus_op(1'b1, 24'h000024, 32'd1, '0, 1'b0);
      bus_op(1'b1, 24'h002000, 32'h2A0, '0, 1'b0);
      gate[9] = 1'b1; @(negedge clk); gate[9] = 1'b0;
      final_id = 8'd9;
      bus_op(1'b0, 24'h200004, '0, 32'd0, 1'b0);
      n_chk++; if (ip_r !== 32'h200) begin n_fail++; $display("FAIL thr_eq_ip: got %h want 200", ip_r); end
      n_chk++; if (claim_id !== 8'd0) begin n_fail++; $display("FAIL thr_eq_id: got %0d want 0", claim_id); end
      bus_op(1'b1, 24'h200000, 32'd0, '0, 1'b0);
      bus_op(1'b0, 24'h200004, '0, 32'd9, 1'b0);
      n_chk++; if ({ip_r, claim_id} !== {32'h0, 8'd9}) begin n_fail++; $display("FAIL thr_lo_claim: got ip=%h id=%0d want ip=0 id=9", ip_r, claim_id); end
      bus_op(1'b1, 24'h200004, 32'd9, '0, 1'b0);
      bus_op(1'b1, 24'h00000C, 32'd2, '0, 1'b0);
      bus_op(1'b1, 24'h002000, 32'h2A8, '0, 1'b0);
      gate[3] = 1'b1; @(negedge clk);
      final_id = 8'd3;
      bus_op(1'b0, 24'h200004, '0, 32'd3, 1'b0);
      gate[3] = 1'b0;
      n_chk++; if (ip_r !== 32'h0) begin n_fail++; $display("FAIL clear_wins_ip: got %h want 0", ip_r); end
      n_chk++; if (claim_id !== 8'd3) begin n_fail++; $display("FAIL clear_wins_id: got %0d want 3", claim_id); end
      bus_op(1'b1, 24'h200004, 32'd3, '0, 1'b0);
      repeat (2) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_chk++;
         if (act_q.size() == 0) begin n_fail++; $display("FAIL thr_rsp: got none want err=%b rdata=%h", e[32], e[31:0]); end
         else begin a = act_q.pop_front(); if (a !== e) begin n_fail++; $display("FAIL thr_rsp: got err=%b rdata=%h want err=%b rdata=%h", a[32], a[31:0], e[32], e[31:0]); end end
      end
      n_chk++; if (act_q.size() != 0) begin n_fail++; $display("FAIL thr_extra_rsp: got %0d want 0", act_q.size()); act_q.delete(); end
   endtask

   task automatic test_errors_back_to_back;
      logic [32:0] e, a;
      for (int i = 0; i < DEPTH; i++) bus_op(1'b1, AW'(4 * (20 + i)), 32'(i + 2), '0, 1'b0);
      bus_op(1'b1, 24'h000060, 32'd7, '0, 1'b0);
      bus_op(1'b1, 24'h002000, 32'h01F0_0000, '0, 1'b0);
      gate[24:20] = 5'h1F; @(negedge clk); gate = '0;
      for (int i = 0; i < DEPTH; i++) begin
         final_id = 8'(20 + i);
         bus_op(1'b0, 24'h200004, '0, 32'(20 + i), 1'b0);
         n_chk++; if (claim_id !== 8'(20 + i)) begin n_fail++; $display("FAIL fill_id%0d: got %0d want %0d", i, claim_id, 20 + i); end
      end
      final_id = 8'd24;
      bus_op(1'b0, 24'h200004, '0, 32'd0, 1'b1);
      n_chk++; if ({ip_r, claim_id} !== {32'h0100_0000, 8'd23}) begin n_fail++; $display("FAIL full_claim: got ip=%h id=%0d want ip=01000000 id=23", ip_r, claim_id); end
      bus_op(1'b1, 24'h200004, 32'd12, '0, 1'b1);
      n_chk++; if ({cmplt_id, claim_id} !== {8'd12, 8'd23}) begin n_fail++; $display("FAIL cmplt_mismatch: got cmplt=%0d id=%0d want 12/23", cmplt_id, claim_id); end
      bus_op(1'b1, 24'h200004, 32'd0, '0, 1'b1);
      n_chk++; if (cmplt_id !== 8'd0) begin n_fail++; $display("FAIL cmplt_zero: got %0d want 0", cmplt_id); end
      bus_op(1'b1, 24'h200004, 32'd40, '0, 1'b1);
      n_chk++; if (cmplt_id !== 8'd0) begin n_fail++; $display("FAIL cmplt_illegal: got %0d want 0", cmplt_id); end
      bus_op(1'b0, 24'h003000, '0, '0, 1'b1);
      bus_op(1'b1, 24'h001000, 32'hFFFF, '0, 1'b1);
      n_chk++; if (ip_r !== 32'h0100_0000) begin n_fail++; $display("FAIL ip_write_ignored: got %h want 01000000", ip_r); end
      for (int i = DEPTH - 1; i >= 0; i--) begin
         bus_op(1'b1, 24'h200004, 32'(20 + i), '0, 1'b0);
         n_chk++; if (cmplt_id !== 8'(20 + i)) begin n_fail++; $display("FAIL b2b_cmplt%0d: got %0d want %0d", i, cmplt_id, 20 + i); end
         n_chk++; if (claim_id !== ((i == 0) ? 8'd0 : 8'(19 + i))) begin n_fail++; $display("FAIL b2b_pop%0d: got %0d", i, claim_id); end
      end
      repeat (2) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_chk++;
         if (act_q.size() == 0) begin n_fail++; $display("FAIL err_rsp: got none want err=%b rdata=%h", e[32], e[31:0]); end
         else begin a = act_q.pop_front(); if (a !== e) begin n_fail++; $display("FAIL err_rsp: got err=%b rdata=%h want err=%b rdata=%h", a[32], a[31:0], e[32], e[31:0]); end end
      end
      n_chk++; if (act_q.size() != 0) begin n_fail++; $display("FAIL err_extra_rsp: got %0d want 0", act_q.size()); act_q.delete(); end
   endtask

   task automatic test_reset_mid;
      final_id = 8'd24;
      bus.bus_req_valid = 1'b1; bus.bus_req_we = 1'b0; bus.bus_req_addr = 24'h200004;
      @(posedge clk);
      #1 rst = 1'b1;
      bus.bus_req_valid = 1'b0;
      @(negedge clk);
      n_chk++; if (bus.bus_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rsp_valid: got %b want 0", bus.bus_rsp_valid); end
      n_chk++; if ({ip_r, ie_r, threshold_r, claim_id, cmplt_id} !== '0) begin n_fail++; $display("FAIL mid_outputs: got %h want 0", {ip_r, ie_r, threshold_r, claim_id, cmplt_id}); end
      n_chk++; if (prio_r_1d !== '0) begin n_fail++; $display("FAIL mid_prio: got %h want 0", prio_r_1d); end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_chk++; if (act_q.size() != 0) begin n_fail++; $display("FAIL mid_dropped_rsp: got %0d responses want 0", act_q.size()); act_q.delete(); end
      n_chk++; if (bus.bus_req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", bus.bus_req_ready); end
   endtask

   initial begin
      test_reset();
      test_claim();
      test_nesting();
      test_threshold_clear();
      test_errors_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
